// File: rtl/matrix_kernel_sdiv_32s_28ns_seq_pkg.sv
// Shared constants for the sequential 32s / 28ns divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_kernel_sdiv_32s_28ns_seq_pkg;

    // FSM encoding, kept as plain constants so older tools can read the state register
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One restoring step per dividend bit
    localparam int ITER_COUNT = 32;

    // Saturated quotients reported for a zero divisor
    localparam logic [31:0] QMAX = 32'h7FFF_FFFF;
    localparam logic [31:0] QMIN = 32'h8000_0000;

endpackage

// File: rtl/matrix_kernel_div_step.sv
// One restoring radix-2 division step: shift in a dividend bit, trial-subtract, select.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module matrix_kernel_div_step #(
    parameter int DIVISOR_W = 28
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] diff;
    logic                 borrow;
    logic                 unused_top;

    // The partial remainder is always below the divisor, so the shifted value's top bit
    // and the kept difference's top bit are both zero; they only exist to make the
    // borrow of the trial subtraction visible.
    always_comb begin
        shifted          = {rem_in, bit_in};
        {borrow, diff}   = {1'b0, shifted} - {3'b000, divisor};
        q_bit            = ~borrow;
        rem_out          = borrow ? shifted[DIVISOR_W:0] : diff[DIVISOR_W:0];
        unused_top       = shifted[DIVISOR_W+1] ^ diff[DIVISOR_W+1];
    end

endmodule

// File: rtl/matrix_kernel_sdiv_32s_28ns_seq.sv
// Sequential signed / unsigned divider with C-style truncating quotient and remainder.
// Latency: accept edge E -> out_valid after E+33 (E+1 for a zero divisor), +1 per ce-low cycle.
// Backpressure: in_ready only in IDLE with ce high; result held in DONE until out_ready.
module matrix_kernel_sdiv_32s_28ns_seq
    import matrix_kernel_sdiv_32s_28ns_seq_pkg::*;
#(
    parameter int ID         = 1,
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W:0]    remainder,
    output logic                  div_by_zero
);

    localparam logic [5:0] LAST_ITER = 6'(ITER_COUNT - 1);

    logic [1:0]            state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    // Holds |dividend| at accept; quotient bits shift in at the bottom as dividend bits leave the top
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic                  neg_q, neg_d;
    logic                  zero_q, zero_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W:0]    remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;

    logic [DIVIDEND_W:0]   mag_w;
    logic                  unused_mag_top;
    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q_bit;

    matrix_kernel_div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[DIVIDEND_W-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q_bit)
    );

    // Magnitude is formed one bit wider so that the most negative dividend maps to 2^31
    always_comb begin
        if (dividend[DIVIDEND_W-1]) begin
            mag_w = (DIVIDEND_W+1)'(0) - {dividend[DIVIDEND_W-1], dividend};
        end else begin
            mag_w = {1'b0, dividend};
        end
        unused_mag_top = mag_w[DIVIDEND_W];
    end

    assign in_ready    = (state_q == ST_IDLE) && ce;
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

    // Next-state logic; everything holds while ce is low
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        dsr_d       = dsr_q;
        neg_d       = neg_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        neg_d  = dividend[DIVIDEND_W-1];
                        dvd_d  = mag_w[DIVIDEND_W-1:0];
                        dsr_d  = divisor;
                        rem_d  = '0;
                        cnt_d  = '0;
                        zero_d = (divisor == '0);
                        // A zero divisor skips the iteration and saturates in FIXUP
                        state_d = (divisor == '0) ? ST_FIXUP : ST_CALC;
                    end
                end
                ST_CALC: begin
                    dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q_bit};
                    rem_d = step_rem;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    if (zero_q) begin
                        quotient_d  = neg_q ? DIVIDEND_W'(QMIN) : DIVIDEND_W'(QMAX);
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                    end else begin
                        // Divisor is unsigned, so only the dividend sign matters
                        quotient_d  = neg_q ? (DIVIDEND_W'(0) - dvd_q) : dvd_q;
                        remainder_d = neg_q ? ((DIVISOR_W+1)'(0) - rem_q) : rem_q;
                        dbz_d       = 1'b0;
                    end
                    state_d = ST_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            dsr_q       <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            dsr_q       <= dsr_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

endmodule
